// File: rtl/dds_pkg.sv
// Shared waveform codes and sine-ROM geometry for the DDS sample source.
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SINE   = 2'd3
  } wave_e;

  localparam int SINE_LUT_DEPTH = 64;
  localparam int SINE_AMP_W     = 7;

endpackage

// File: rtl/dds_sine_rom.sv
// Quarter-wave sine ROM, amp = round(127*sin((idx+0.5)*pi/128)).
// Purely combinational; no backpressure.
module dds_sine_rom
  import dds_pkg::*;
(
  input  logic [$clog2(SINE_LUT_DEPTH)-1:0] idx,
  output logic [SINE_AMP_W-1:0]             amp
);

  localparam logic [SINE_AMP_W-1:0] LUT [SINE_LUT_DEPTH] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  assign amp = LUT[idx];

endmodule

// File: rtl/dds_sample_gen.sv
// DDS saw/square/triangle sample source for the sigma-delta DAC; WAVE=3 is ROM sine under DDS_SINE_LUT_EN, else triangle.
// Latency: enabled tick in T -> SAMPLE_o updated end of T+1, STB_o high in T+2; no backpressure.
module dds_sample_gen
  import dds_pkg::*;
#(
  parameter int MSBI     = 7,
  parameter int PHASE_W  = 24,
  parameter int DIV_W    = 16,
  parameter int RATE_DIV = 256
) (
  input  logic               CLK_i,
  input  logic               RSTn_i,
  input  logic               ENABLE_i,
  input  logic               LOAD_i,
  input  logic [PHASE_W-1:0] FTW_i,
  input  logic [1:0]         WAVE_i,
  output logic [MSBI:0]      SAMPLE_o,
  output logic               STB_o
);

  localparam int N = MSBI + 1;

  logic [DIV_W-1:0]   div_q;
  logic               tick;
  logic               en_tick;
  logic               apply;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] ftw_q;
  logic [PHASE_W-1:0] shd_ftw_q;
  logic [PHASE_W-1:0] ftw_eff;
  wave_e              wave_q;
  wave_e              shd_wave_q;
  logic               pend_q;
  logic               upd_q;
  logic               stb_q;
  logic [N-1:0]       smp_q;
  logic [N-1:0]       smp_nxt;

  assign tick    = (div_q == DIV_W'(RATE_DIV - 1));
  assign en_tick = tick & ENABLE_i;
  assign apply   = en_tick & pend_q;
  // A freshly applied tuning word takes effect in the same tick's phase add.
  assign ftw_eff = apply ? shd_ftw_q : ftw_q;

  always_ff @(posedge CLK_i) begin
    if (!RSTn_i) begin
      div_q      <= '0;
      phase_q    <= '0;
      ftw_q      <= '0;
      wave_q     <= WAVE_SAW;
      shd_ftw_q  <= '0;
      shd_wave_q <= WAVE_SAW;
      pend_q     <= 1'b0;
      upd_q      <= 1'b0;
      stb_q      <= 1'b0;
      smp_q      <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + DIV_W'(1);
      if (LOAD_i) begin
        shd_ftw_q  <= FTW_i;
        shd_wave_q <= wave_e'(WAVE_i);
      end
      // A load landing on the applying tick stays pending for the next tick.
      pend_q <= LOAD_i | (pend_q & ~apply);
      if (apply) begin
        ftw_q  <= shd_ftw_q;
        wave_q <= shd_wave_q;
      end
      if (en_tick) begin
        phase_q <= phase_q + ftw_eff;
      end
      upd_q <= en_tick;
      stb_q <= upd_q;
      if (upd_q) begin
        smp_q <= smp_nxt;
      end
    end
  end

  logic         msb;
  logic [N-1:0] tri_x;
  logic [N-1:0] tri_smp;

  assign msb     = phase_q[PHASE_W-1];
  assign tri_x   = phase_q[PHASE_W-2 -: N];
  assign tri_smp = msb ? ~tri_x : tri_x;

`ifdef DDS_SINE_LUT_EN
  logic [1:0]                        quad;
  logic [$clog2(SINE_LUT_DEPTH)-1:0] rom_idx;
  logic [SINE_AMP_W-1:0]             amp;
  logic [N-1:0]                      sine_smp;

  assign quad    = phase_q[PHASE_W-1 -: 2];
  // Odd quadrants walk the quarter-wave table backwards.
  assign rom_idx = quad[0] ? ~phase_q[PHASE_W-3 -: $clog2(SINE_LUT_DEPTH)]
                           :  phase_q[PHASE_W-3 -: $clog2(SINE_LUT_DEPTH)];

  dds_sine_rom u_sine_rom (
    .idx (rom_idx),
    .amp (amp)
  );

  // 128+amp in the positive half, 127-amp in the negative half.
  assign sine_smp = quad[1] ? {1'b0, ~amp} : {1'b1, amp};
`endif

  always_comb begin
    smp_nxt = tri_smp;
    case (wave_q)
      WAVE_SAW:    smp_nxt = phase_q[PHASE_W-1 -: N];
      WAVE_SQUARE: smp_nxt = msb ? '0 : '1;
      WAVE_TRI:    smp_nxt = tri_smp;
`ifdef DDS_SINE_LUT_EN
      WAVE_SINE:   smp_nxt = sine_smp;
`endif
      default:     smp_nxt = tri_smp;
    endcase
  end

  assign SAMPLE_o = smp_q;
  assign STB_o    = stb_q;

endmodule

// File: tb/tb_dds_sample_gen.sv
// Directed bench for dds_sample_gen with a 4-clock sample rate.
module tb_dds_sample_gen;

  localparam int MSBI     = 7;
  localparam int PHASE_W  = 24;
  localparam int DIV_W    = 16;
  localparam int RATE_DIV = 4;

  logic               CLK_i = 1'b0;
  logic               RSTn_i;
  logic               ENABLE_i;
  logic               LOAD_i;
  logic [PHASE_W-1:0] FTW_i;
  logic [1:0]         WAVE_i;
  logic [MSBI:0]      SAMPLE_o;
  logic               STB_o;

  int checks = 0;
  int errors = 0;

  always #5 CLK_i = ~CLK_i;

  dds_sample_gen #(
    .MSBI     (MSBI),
    .PHASE_W  (PHASE_W),
    .DIV_W    (DIV_W),
    .RATE_DIV (RATE_DIV)
  ) dut (
    .CLK_i    (CLK_i),
    .RSTn_i   (RSTn_i),
    .ENABLE_i (ENABLE_i),
    .LOAD_i   (LOAD_i),
    .FTW_i    (FTW_i),
    .WAVE_i   (WAVE_i),
    .SAMPLE_o (SAMPLE_o),
    .STB_o    (STB_o)
  );

  typedef struct {
    logic [23:0] ftw;
    logic [1:0]  wave;
    int          k;     // strobe number after the load
    int          exp;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_stb(output logic [31:0] smp, output int cyc, output bit ok);
    ok  = 1'b0;
    smp = '0;
    cyc = 0;
    while (!ok && cyc < 64) begin
      @(negedge CLK_i);
      cyc++;
      if (STB_o === 1'b1) begin
        smp = 32'(SAMPLE_o);
        ok  = 1'b1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL stb_timeout: actual=no strobe in 64 cycles required=strobe");
    end
  endtask

  task automatic restart(input logic [23:0] ftw, input logic [1:0] wave, input bit do_load);
    @(negedge CLK_i);
    RSTn_i   = 1'b0;
    LOAD_i   = 1'b0;
    ENABLE_i = 1'b1;
    repeat (3) @(negedge CLK_i);
    RSTn_i = 1'b1;
    if (do_load) begin
      LOAD_i = 1'b1;
      FTW_i  = ftw;
      WAVE_i = wave;
    end
    @(negedge CLK_i);
    LOAD_i = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] s;
    int          c;
    bit          ok;
    int          seen;
    int          nstb;
    bit          held;
    logic [23:0] cur_ftw;
    logic [1:0]  cur_wave;

    RSTn_i   = 1'b0;
    ENABLE_i = 1'b0;
    LOAD_i   = 1'b0;
    FTW_i    = '0;
    WAVE_i   = '0;

    vecs[0]  = '{24'h010000, 2'd0, 1,   1};
    vecs[1]  = '{24'h010000, 2'd0, 2,   2};
    vecs[2]  = '{24'h010000, 2'd0, 255, 255};
    vecs[3]  = '{24'h010000, 2'd0, 256, 0};
    vecs[4]  = '{24'h010000, 2'd0, 257, 1};
    vecs[5]  = '{24'h010000, 2'd2, 1,   2};
    vecs[6]  = '{24'h010000, 2'd2, 127, 254};
    vecs[7]  = '{24'h010000, 2'd2, 128, 255};
    vecs[8]  = '{24'h010000, 2'd2, 129, 253};
    vecs[9]  = '{24'h010000, 2'd2, 255, 1};
    vecs[10] = '{24'h010000, 2'd2, 256, 0};
    vecs[11] = '{24'h010000, 2'd2, 257, 2};
    vecs[12] = '{24'h400000, 2'd1, 1,   255};
    vecs[13] = '{24'h400000, 2'd1, 2,   0};
    vecs[14] = '{24'h400000, 2'd1, 3,   0};
    vecs[15] = '{24'h400000, 2'd1, 4,   255};
    vecs[16] = '{24'h400000, 2'd1, 5,   255};
    vecs[17] = '{24'h400000, 2'd1, 6,   0};
    vecs[18] = '{24'h400000, 2'd1, 7,   0};
    vecs[19] = '{24'h400000, 2'd1, 8,   255};
`ifdef DDS_SINE_LUT_EN
    vecs[20] = '{24'h400000, 2'd3, 1,   255};
    vecs[21] = '{24'h400000, 2'd3, 2,   125};
    vecs[22] = '{24'h400000, 2'd3, 3,   0};
    vecs[23] = '{24'h400000, 2'd3, 4,   130};
`else
    vecs[20] = '{24'h400000, 2'd3, 1,   128};
    vecs[21] = '{24'h400000, 2'd3, 2,   255};
    vecs[22] = '{24'h400000, 2'd3, 3,   127};
    vecs[23] = '{24'h400000, 2'd3, 4,   0};
`endif

    repeat (3) @(negedge CLK_i);
    check("reset_sample", 32'(SAMPLE_o), 0);
    check("reset_stb", 32'(STB_o), 0);

    // First strobe timing and period.
    restart(24'h010000, 2'd0, 1'b1);
    wait_stb(s, c, ok);
    check("first_stb_latency", c, 4);
    check("first_sample", s, 1);
    wait_stb(s, c, ok);
    check("stb_period", c, 4);
    check("second_sample", s, 2);

    seen     = 0;
    cur_ftw  = '0;
    cur_wave = '0;
    for (int i = 0; i < NV; i++) begin
      if (i == 0 || vecs[i].ftw != cur_ftw || vecs[i].wave != cur_wave || vecs[i].k <= seen) begin
        restart(vecs[i].ftw, vecs[i].wave, 1'b1);
        cur_ftw  = vecs[i].ftw;
        cur_wave = vecs[i].wave;
        seen     = 0;
      end
      ok = 1'b1;
      while (ok && seen < vecs[i].k) begin
        wait_stb(s, c, ok);
        seen++;
      end
      if (ok) check($sformatf("vec%0d", i), s, vecs[i].exp);
    end

    // Mid-run reset with a pending load: the load must be discarded.
    restart(24'h010000, 2'd0, 1'b1);
    repeat (3) wait_stb(s, c, ok);
    LOAD_i = 1'b1;
    FTW_i  = 24'h050000;
    @(negedge CLK_i);
    LOAD_i = 1'b0;
    RSTn_i = 1'b0;
    repeat (3) @(negedge CLK_i);
    check("midrst_sample", 32'(SAMPLE_o), 0);
    check("midrst_stb", 32'(STB_o), 0);
    RSTn_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_stb(s, c, ok);
      if (ok) check("ftw0_after_rst", s, 0);
    end

    // LOAD coinciding with a tick, then last-load-wins before the next tick.
    restart(24'h010000, 2'd0, 1'b1);
    wait_stb(s, c, ok);
    check("coll_pre", s, 1);
    @(negedge CLK_i);
    @(negedge CLK_i);
    LOAD_i = 1'b1;
    FTW_i  = 24'h020000;
    @(negedge CLK_i);
    LOAD_i = 1'b0;
    wait_stb(s, c, ok);
    check("coll_same_tick", s, 2);
    wait_stb(s, c, ok);
    check("coll_next_tick", s, 4);
    LOAD_i = 1'b1;
    FTW_i  = 24'h070000;
    @(negedge CLK_i);
    FTW_i  = 24'h030000;
    @(negedge CLK_i);
    LOAD_i = 1'b0;
    wait_stb(s, c, ok);
    check("last_load_wins", s, 7);

    // Disable for three tick periods with a load left pending.
    ENABLE_i = 1'b0;
    nstb     = 0;
    held     = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK_i);
      LOAD_i = (i == 4);
      if (i == 4) FTW_i = 24'h010000;
      if (STB_o !== 1'b0) nstb++;
      if (SAMPLE_o !== 8'd7) held = 1'b0;
    end
    check("dis_no_stb", nstb, 0);
    check("dis_hold", 32'(held), 1);
    ENABLE_i = 1'b1;
    wait_stb(s, c, ok);
    check("en_pending_applied", s, 8);
    wait_stb(s, c, ok);
    check("en_next", s, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
